// File: rtl/button_conditioner_pkg.sv
// Shared state encoding, default timing constants and width helpers
// for the push-button conditioner.
`timescale 1ns/1ps
package button_conditioner_pkg;

    typedef logic [1:0] state_t;

    localparam state_t REL = 2'd0;
    localparam state_t PRS = 2'd1;
    localparam state_t GAP = 2'd2;
    localparam state_t RPT = 2'd3;

    // Defaults assume a 50 MHz system clock.
    localparam int DEF_NUM_BUTTONS     = 4;
    localparam int DEF_ACTIVE_LOW      = 1;
    localparam int DEF_DEBOUNCE_CYCLES = 1000000;
    localparam int DEF_HOLD_CYCLES     = 50000000;
    localparam int DEF_REPEAT_CYCLES   = 10000000;
    localparam int DEF_REPEAT_GAP      = 4;

    function automatic int cnt_width(input int n);
        return $clog2(n) + 1;
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/button_conditioner_channel.sv
// One button channel: two-flop synchronizer, debounce counter and the
// press/hold/auto-repeat state machine driving the active-low key stream.
`timescale 1ns/1ps
module button_conditioner_channel
    import button_conditioner_pkg::*;
#(
    parameter int ACTIVE_LOW      = DEF_ACTIVE_LOW,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int HOLD_CYCLES     = DEF_HOLD_CYCLES,
    parameter int REPEAT_CYCLES   = DEF_REPEAT_CYCLES,
    parameter int REPEAT_GAP      = DEF_REPEAT_GAP,
    parameter bit REPEAT_EN       = 1'b1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic btn_raw,
    output logic key_n_out,
    output logic pressed,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_press
);

    localparam logic IDLE_LVL = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

    localparam int DB_W   = cnt_width(DEBOUNCE_CYCLES);
    localparam int HOLD_W = cnt_width(HOLD_CYCLES);
    localparam int REP_W  = cnt_width(max_int(REPEAT_CYCLES, REPEAT_GAP));

    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DB_W-1:0]   DB_ONE    = DB_W'(1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_SAT  = HOLD_W'(HOLD_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
    localparam logic [REP_W-1:0]  GAP_LAST  = REP_W'(REPEAT_GAP - 1);
    localparam logic [REP_W-1:0]  RPT_LAST  = REP_W'(REPEAT_CYCLES - 1);
    localparam logic [REP_W-1:0]  REP_ONE   = REP_W'(1);

    logic              sync_p0;
    logic              sync_p1;
    logic              s;
    logic              stable;
    logic [DB_W-1:0]   db_cnt;
    state_t            state;
    logic [HOLD_W-1:0] hold_cnt;
    logic [REP_W-1:0]  rep_cnt;

    // Stage p0/p1: metastability filter; reset to the idle pin level so a
    // key held through reset is seen as a fresh press.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_p0 <= IDLE_LVL;
            sync_p1 <= IDLE_LVL;
        end else begin
            sync_p0 <= btn_raw;
            sync_p1 <= sync_p0;
        end
    end

    assign s = sync_p1 ^ IDLE_LVL;

    // Debounce: accept a change only after it has persisted unbroken.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stable <= 1'b0;
            db_cnt <= '0;
        end else if (s != stable) begin
            if (db_cnt == DB_LAST) begin
                stable <= s;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + DB_ONE;
            end
        end else begin
            db_cnt <= '0;
        end
    end

    assign pressed = stable;

    // Hold FSM; release is tested first in every pressed state so it wins
    // over a hold or repeat transition landing on the same cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= REL;
            hold_cnt      <= '0;
            rep_cnt       <= '0;
            key_n_out     <= 1'b1;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            long_press    <= 1'b0;
        end else begin
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            long_press    <= 1'b0;
            case (state)
                REL: begin
                    key_n_out <= 1'b1;
                    if (stable) begin
                        state       <= PRS;
                        hold_cnt    <= '0;
                        press_pulse <= 1'b1;
                        key_n_out   <= 1'b0;
                    end
                end
                PRS: begin
                    if (!stable) begin
                        state         <= REL;
                        release_pulse <= 1'b1;
                        key_n_out     <= 1'b1;
                    end else if (hold_cnt == HOLD_LAST) begin
                        long_press <= 1'b1;
                        if (REPEAT_EN) begin
                            state     <= GAP;
                            rep_cnt   <= '0;
                            key_n_out <= 1'b1;
                        end else begin
                            hold_cnt  <= hold_cnt + HOLD_ONE;
                            key_n_out <= 1'b0;
                        end
                    end else begin
                        // Parks at HOLD_CYCLES when repeat is disabled so
                        // long_press cannot fire twice.
                        if (hold_cnt < HOLD_SAT) begin
                            hold_cnt <= hold_cnt + HOLD_ONE;
                        end
                        key_n_out <= 1'b0;
                    end
                end
                GAP: begin
                    if (!stable) begin
                        state         <= REL;
                        release_pulse <= 1'b1;
                        key_n_out     <= 1'b1;
                    end else if (rep_cnt == GAP_LAST) begin
                        state     <= RPT;
                        rep_cnt   <= '0;
                        key_n_out <= 1'b0;
                    end else begin
                        rep_cnt   <= rep_cnt + REP_ONE;
                        key_n_out <= 1'b1;
                    end
                end
                RPT: begin
                    if (!stable) begin
                        state         <= REL;
                        release_pulse <= 1'b1;
                        key_n_out     <= 1'b1;
                    end else if (rep_cnt == RPT_LAST) begin
                        state     <= GAP;
                        rep_cnt   <= '0;
                        key_n_out <= 1'b1;
                    end else begin
                        rep_cnt   <= rep_cnt + REP_ONE;
                        key_n_out <= 1'b0;
                    end
                end
                default: begin
                    state     <= REL;
                    key_n_out <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/button_conditioner.sv
// Debounce, hold detection and auto-repeat for a bank of push buttons,
// producing an active-low key stream for edge-capturing PIO inputs.
`timescale 1ns/1ps
module button_conditioner
    import button_conditioner_pkg::*;
#(
    parameter int                     NUM_BUTTONS     = DEF_NUM_BUTTONS,
    parameter int                     ACTIVE_LOW      = DEF_ACTIVE_LOW,
    parameter int                     DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int                     HOLD_CYCLES     = DEF_HOLD_CYCLES,
    parameter int                     REPEAT_CYCLES   = DEF_REPEAT_CYCLES,
    parameter int                     REPEAT_GAP      = DEF_REPEAT_GAP,
    parameter logic [NUM_BUTTONS-1:0] REPEAT_MASK     = {NUM_BUTTONS{1'b1}}
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [NUM_BUTTONS-1:0] btn_raw,
    output logic [NUM_BUTTONS-1:0] key_n_out,
    output logic [NUM_BUTTONS-1:0] pressed,
    output logic [NUM_BUTTONS-1:0] press_pulse,
    output logic [NUM_BUTTONS-1:0] release_pulse,
    output logic [NUM_BUTTONS-1:0] long_press
);

    for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_chan
        button_conditioner_channel #(
            .ACTIVE_LOW      (ACTIVE_LOW),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .HOLD_CYCLES     (HOLD_CYCLES),
            .REPEAT_CYCLES   (REPEAT_CYCLES),
            .REPEAT_GAP      (REPEAT_GAP),
            .REPEAT_EN       (REPEAT_MASK[i])
        ) u_chan (
            .clk           (clk),
            .reset_n       (reset_n),
            .btn_raw       (btn_raw[i]),
            .key_n_out     (key_n_out[i]),
            .pressed       (pressed[i]),
            .press_pulse   (press_pulse[i]),
            .release_pulse (release_pulse[i]),
            .long_press    (long_press[i])
        );
    end

endmodule
